bf_stream_ctrl: RTL and testbench
=================================

# bf_stream_ctrl

Control-plane sequencer for the four-channel beamforming weighting datapath. It aligns the four 128-bit sample streams (channels 00, 01, 20, 21) so the datapath consumes one beat from every channel in the same cycle. It holds double-buffered complex weights and swaps them only at frame boundaries. It detects and recovers from tlast misalignment and frame-length errors. The block carries no sample data; it drives the s*_axis_tready lines and the datapath fire/tlast, and presents the active weight set to the datapath weight inputs.

## Interface
- NUM_CH, 4: number of input channels.
- WEIGHT_WIDTH, 9: bits per weight component (real or imag), two's complement.
- FRAME_LEN, 64: expected beats per frame; tlast is expected on beat FRAME_LEN-1.
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- s_tvalid  in  NUM_CH  per-channel input tvalid.
- s_tlast  in  NUM_CH  per-channel input tlast.
- s_tready  out  NUM_CH  per-channel input tready.
- dp_tready  in  1  downstream (m_axis_s2mm) tready.
- dp_fire  out  1  all channels transfer this cycle; the datapath consumes data.
- dp_tlast  out  1  tlast for the fired beat.
- cfg_wr_en  in  1  shadow-weight write strobe.
- cfg_wr_addr  in  3  {channel[1:0], imag}; channel 0..3 = 00, 01, 20, 21.
- cfg_wr_data  in  WEIGHT_WIDTH  weight component.
- cfg_commit  in  1  request shadow→active swap.
- weights  out  NUM_CH*2*WEIGHT_WIDTH  active set; slice index = ch*2+imag.
- commit_pending  out  1  commit requested, not yet applied.
- commit_done  out  1  one-cycle pulse after a swap.
- err_misalign  out  1  sticky: tlast bits disagreed on a fired beat.
- err_frame_len  out  1  sticky: tlast missing at, or early before, beat FRAME_LEN-1.
- err_clear  in  1  clears both sticky errors.
- frame_count  out  16  count of completed aligned frames; wraps.

## Operation
- States: INIT, RUN, SWAP, DRAIN.
- Reset: state=INIT; all outputs 0, including weights, shadow, beat counter, and frame_count.
- INIT: s_tready=0. cfg_commit moves to SWAP.
- RUN:
  - all_valid = &s_tvalid.
  - fire = all_valid & dp_tready.
  - s_tready[i] = fire for every i, so all channels transfer together or none do.
  - dp_fire = fire; dp_tlast = s_tlast[0].
  - Beat counter increments on each fire.
- Misalignment: a fire with s_tlast neither all-0 nor all-1 sets err_misalign and moves to DRAIN.
  - The beat counter clears.
  - done[i] is set for each channel whose tlast was 1 on that beat.
- Aligned tlast fire:
  - frame_count increments; the beat counter clears.
  - If the counter ≠ FRAME_LEN-1, err_frame_len is set.
  - Then go to SWAP if commit_pending is 1, else stay in RUN.
- Missing tlast: counter = FRAME_LEN-1 on a fire without tlast sets err_frame_len; the counter wraps to 0 and the block stays in RUN.
- DRAIN:
  - dp_fire=0; s_tready[i] = ~done[i], so beats are discarded.
  - A channel's tlast transfer sets done[i].
  - When all done bits are set, clear them and go to RUN.
- SWAP (one cycle):
  - s_tready=0; active ← shadow; commit_pending cleared.
  - commit_done pulses the next cycle; next state RUN.
- cfg_wr_en writes the shadow in any state, including while a commit is pending.
- Same-cycle cfg_wr_en and SWAP: the active set takes the pre-write shadow value; the write lands in the shadow only.
- cfg_commit:
  - Sets commit_pending.
  - Repeated commits while pending are no-ops.
  - A commit in the same cycle as a SWAP re-arms pending.
- err_clear and an error set in the same cycle: set wins.
- Reset mid-frame or in DRAIN: everything returns to INIT. Weights return to 0 and a new commit is required.

## Timing
- s_tready and dp_fire/dp_tlast: combinational from s_tvalid, s_tlast, dp_tready and the registered state. There is no path from the datapath outputs back into these signals.
- weights: registered; changes visible the cycle after SWAP.
- Throughput: one beat per cycle in RUN. Each committed frame boundary costs exactly one stall cycle (SWAP).
- Flags: commit_pending, error flags and frame_count are registered and update the cycle after their cause.
- INIT→RUN via SWAP: first possible fire is 2 cycles after cfg_commit.

## Structure
- Package bf_pkg holds:
  - the state enum;
  - the NUM_CH and WEIGHT_WIDTH defaults;
  - the cfg address encoding (channel index, imag bit);
  - the weights slice-index function.
- Sub-module bf_weight_bank holds the shadow and active registers, the write port and the swap strobe.
- bf_stream_ctrl holds the FSM, beat/frame counters, done bits and error flags.

## Test plan
- Write 8 shadow weights (e.g. ch0 real=0x0FF, imag=0x101), commit from INIT → weights updates 2 cycles later, commit_done pulses once, s_tready stays 0 until then.
- All channels valid, dp_tready toggling 1/0, FRAME_LEN=4 frames → dp_fire only when dp_tready=1, frame_count increments per tlast, no errors.
- Commit mid-frame plus a new shadow write → old weights hold to tlast, one SWAP stall cycle, new weights afterwards. A write in the SWAP cycle does not reach the active set.
- Channel 2 asserts tlast one beat early → err_misalign=1, DRAIN discards channels 0, 1 and 3 up to their tlast, then RUN resumes aligned. Assert err_clear → flag clears.
- Frame of 6 beats with FRAME_LEN=4 → err_frame_len set at beat 3, counter wraps, frame_count increments once at the tlast.
- Assert reset while in DRAIN with commit_pending=1 → all outputs 0, state INIT, pending cleared.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared types and constants for the beamforming stream sequencer:
// FSM state encoding, default sizes, cfg address layout and weight slicing.
package bf_pkg;

   localparam int BF_NUM_CH       = 4;
   localparam int BF_WEIGHT_WIDTH = 9;
   localparam int BF_FRAME_LEN    = 64;

   // cfg_wr_addr = {channel[1:0], imag}
   localparam int CFG_ADDR_W   = 3;
   localparam int CFG_CH_MSB   = 2;
   localparam int CFG_CH_LSB   = 1;
   localparam int CFG_IMAG_BIT = 0;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SWAP  = 2'd2,
      ST_DRAIN = 2'd3
   } bf_state_e;

   // Slot of one weight component inside the flat weights bus.
   function automatic int weight_slice(input logic [1:0] ch, input logic imag);
      return 2 * int'(ch) + int'(imag);
   endfunction

endpackage

// File: rtl/bf_weight_bank.sv
// Double-buffered complex weight store: cfg writes land in the shadow set,
// and a one-cycle swap strobe copies shadow into the active set.
module bf_weight_bank
   import bf_pkg::*;
#(
   parameter int NUM_CH       = BF_NUM_CH,
   parameter int WEIGHT_WIDTH = BF_WEIGHT_WIDTH
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             wr_en,
   input  logic [CFG_ADDR_W-1:0]            wr_addr,
   input  logic [WEIGHT_WIDTH-1:0]          wr_data,
   input  logic                             swap,
   output logic [NUM_CH*2*WEIGHT_WIDTH-1:0] weights,
   output logic                             swap_done
);

   localparam int SLOTS = NUM_CH * 2;

   logic [SLOTS*WEIGHT_WIDTH-1:0] shadow_q;
   logic [SLOTS*WEIGHT_WIDTH-1:0] active_q;
   logic                          swap_done_q;
   int                            wr_slot;

   always_comb begin
      wr_slot = weight_slice(wr_addr[CFG_CH_MSB:CFG_CH_LSB], wr_addr[CFG_IMAG_BIT]);
   end

   // The swap reads shadow_q before any same-cycle write lands, so a write
   // issued during the swap only affects the next commit.
   always_ff @(posedge clock) begin
      if (reset) begin
         shadow_q    <= '0;
         active_q    <= '0;
         swap_done_q <= 1'b0;
      end else begin
         swap_done_q <= swap;
         if (swap) begin
            active_q <= shadow_q;
         end
         for (int i = 0; i < SLOTS; i++) begin
            if (wr_en && (wr_slot == i)) begin
               shadow_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= wr_data;
            end
         end
      end
   end

   assign weights   = active_q;
   assign swap_done = swap_done_q;

endmodule

// File: rtl/bf_stream_ctrl.sv
// Control sequencer for the four-channel beamforming datapath: lock-step
// stream alignment, frame-boundary weight swaps, and tlast error recovery.
module bf_stream_ctrl
   import bf_pkg::*;
#(
   parameter int NUM_CH       = BF_NUM_CH,
   parameter int WEIGHT_WIDTH = BF_WEIGHT_WIDTH,
   parameter int FRAME_LEN    = BF_FRAME_LEN
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_CH-1:0]                s_tvalid,
   input  logic [NUM_CH-1:0]                s_tlast,
   output logic [NUM_CH-1:0]                s_tready,
   input  logic                             dp_tready,
   output logic                             dp_fire,
   output logic                             dp_tlast,
   input  logic                             cfg_wr_en,
   input  logic [CFG_ADDR_W-1:0]            cfg_wr_addr,
   input  logic [WEIGHT_WIDTH-1:0]          cfg_wr_data,
   input  logic                             cfg_commit,
   output logic [NUM_CH*2*WEIGHT_WIDTH-1:0] weights,
   output logic                             commit_pending,
   output logic                             commit_done,
   output logic                             err_misalign,
   output logic                             err_frame_len,
   input  logic                             err_clear,
   output logic [15:0]                      frame_count,
   output logic [1:0]                       dbg_state
);

   localparam int                BEAT_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);

   bf_state_e         state_q, state_d;
   logic [BEAT_W-1:0] beat_q;
   logic [NUM_CH-1:0] done_q, done_next;
   logic [15:0]       frame_q;
   logic              pending_q, mis_q, flen_q;

   logic all_valid, tlast_all, tlast_any, fire;
   logic misalign, aligned_last, beat_at_last, flen_err, swap;

   always_comb begin
      all_valid    = &s_tvalid;
      tlast_all    = &s_tlast;
      tlast_any    = |s_tlast;
      fire         = (state_q == ST_RUN) && all_valid && dp_tready;
      misalign     = fire && tlast_any && !tlast_all;
      aligned_last = fire && tlast_all;
      beat_at_last = (beat_q == BEAT_LAST);
      flen_err     = (aligned_last && !beat_at_last) ||
                     (fire && !tlast_any && beat_at_last);
      swap         = (state_q == ST_SWAP);
   end

   // Handshake: a channel beat transfers when s_tvalid[i] & s_tready[i].
   // In RUN every tready equals fire, so all channels move together or none
   // do; in DRAIN each unfinished channel is drained on its own up to tlast.
   always_comb begin
      s_tready = '0;
      case (state_q)
         ST_RUN:   s_tready = {NUM_CH{fire}};
         ST_DRAIN: s_tready = ~done_q;
         default:  s_tready = '0;
      endcase
   end

   assign done_next = done_q | (s_tready & s_tvalid & s_tlast);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
            if (cfg_commit) state_d = ST_SWAP;
         end
         ST_RUN: begin
            if (misalign)                       state_d = ST_DRAIN;
            else if (aligned_last && pending_q) state_d = ST_SWAP;
         end
         ST_SWAP: begin
            state_d = ST_RUN;
         end
         ST_DRAIN: begin
            if (&done_next) state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_INIT;
      else       state_q <= state_d;
   end

   // Any tlast, aligned or not, ends the frame for beat counting purposes.
   always_ff @(posedge clock) begin
      if (reset) begin
         beat_q <= '0;
      end else if (fire) begin
         if (tlast_any || beat_at_last) beat_q <= '0;
         else                           beat_q <= beat_q + BEAT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         done_q <= '0;
      end else if (state_q == ST_DRAIN) begin
         done_q <= (&done_next) ? '0 : done_next;
      end else if (misalign) begin
         done_q <= s_tlast;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_q   <= '0;
         pending_q <= 1'b0;
         mis_q     <= 1'b0;
         flen_q    <= 1'b0;
      end else begin
         if (aligned_last) frame_q <= frame_q + 16'd1;

         // A commit arriving during the swap itself arms the next swap.
         if (swap)            pending_q <= cfg_commit;
         else if (cfg_commit) pending_q <= 1'b1;

         if (misalign)       mis_q <= 1'b1;
         else if (err_clear) mis_q <= 1'b0;

         if (flen_err)       flen_q <= 1'b1;
         else if (err_clear) flen_q <= 1'b0;
      end
   end

   bf_weight_bank #(
      .NUM_CH       (NUM_CH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH)
   ) u_bank (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (cfg_wr_en),
      .wr_addr   (cfg_wr_addr),
      .wr_data   (cfg_wr_data),
      .swap      (swap),
      .weights   (weights),
      .swap_done (commit_done)
   );

   assign dp_fire        = fire;
   assign dp_tlast       = fire & s_tlast[0];
   assign commit_pending = pending_q;
   assign err_misalign   = mis_q;
   assign err_frame_len  = flen_q;
   assign frame_count    = frame_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_bf_stream_ctrl.sv
// Directed bench for bf_stream_ctrl with a 4-beat frame length.
module tb_bf_stream_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  s_tvalid = '0;
   logic [3:0]  s_tlast = '0;
   logic [3:0]  s_tready;
   logic        dp_tready = 1'b0;
   logic        dp_fire, dp_tlast;
   logic        cfg_wr_en = 1'b0;
   logic [2:0]  cfg_wr_addr = '0;
   logic [8:0]  cfg_wr_data = '0;
   logic        cfg_commit = 1'b0;
   logic [71:0] weights;
   logic        commit_pending, commit_done, err_misalign, err_frame_len;
   logic        err_clear = 1'b0;
   logic [15:0] frame_count;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [8:0]  w_exp [8];

   bf_stream_ctrl #(.NUM_CH(4), .WEIGHT_WIDTH(9), .FRAME_LEN(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .s_tvalid       (s_tvalid),
      .s_tlast        (s_tlast),
      .s_tready       (s_tready),
      .dp_tready      (dp_tready),
      .dp_fire        (dp_fire),
      .dp_tlast       (dp_tlast),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_wr_addr    (cfg_wr_addr),
      .cfg_wr_data    (cfg_wr_data),
      .cfg_commit     (cfg_commit),
      .weights        (weights),
      .commit_pending (commit_pending),
      .commit_done    (commit_done),
      .err_misalign   (err_misalign),
      .err_frame_len  (err_frame_len),
      .err_clear      (err_clear),
      .frame_count    (frame_count),
      .dbg_state      (dbg_state)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] packw();
      logic [71:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i*9 +: 9] = w_exp[i];
      return v;
   endfunction

   // One fully valid beat at full downstream rate.
   task automatic beat(input logic [3:0] last);
      s_tvalid  = 4'hF;
      dp_tready = 1'b1;
      s_tlast   = last;
      #1;
      check("beat_fire", 128'(dp_fire), 128'(1'b1));
      check("beat_tready", 128'(s_tready), 128'(4'hF));
      check("beat_tlast", 128'(dp_tlast), 128'(last[0]));
      tick();
      s_tlast = '0;
   endtask

   initial begin
      w_exp[0] = 9'h0FF; w_exp[1] = 9'h101; w_exp[2] = 9'h011; w_exp[3] = 9'h022;
      w_exp[4] = 9'h033; w_exp[5] = 9'h044; w_exp[6] = 9'h155; w_exp[7] = 9'h1AA;

      // reset state
      tick();
      tick();
      s_tvalid  = 4'hF;
      dp_tready = 1'b1;
      #1;
      check("rst_state", 128'(dbg_state), 128'(2'd0));
      check("rst_weights", 128'(weights), 128'(72'd0));
      check("rst_frames", 128'(frame_count), 128'(16'd0));
      check("rst_errs", 128'({err_misalign, err_frame_len}), 128'(2'b00));
      check("rst_tready", 128'(s_tready), 128'(4'h0));
      check("rst_fire", 128'(dp_fire), 128'(1'b0));
      reset = 1'b0;

      // shadow writes in INIT do not touch the active set
      for (int i = 0; i < 8; i++) begin
         cfg_wr_en   = 1'b1;
         cfg_wr_addr = 3'(i);
         cfg_wr_data = w_exp[i];
         tick();
      end
      cfg_wr_en = 1'b0;
      check("init_weights", 128'(weights), 128'(72'd0));
      check("init_state", 128'(dbg_state), 128'(2'd0));

      // commit from INIT: SWAP, then RUN with new weights
      cfg_commit = 1'b1;
      #1;
      check("init_tready", 128'(s_tready), 128'(4'h0));
      tick();
      cfg_commit = 1'b0;
      #1;
      check("swap_state", 128'(dbg_state), 128'(2'd2));
      check("swap_pending", 128'(commit_pending), 128'(1'b1));
      check("swap_weights", 128'(weights), 128'(72'd0));
      check("swap_tready", 128'(s_tready), 128'(4'h0));
      check("swap_fire", 128'(dp_fire), 128'(1'b0));
      check("swap_done0", 128'(commit_done), 128'(1'b0));
      s_tvalid = 4'h0;
      tick();
      check("run_state", 128'(dbg_state), 128'(2'd1));
      check("run_weights", 128'(weights), 128'(packw()));
      check("run_done", 128'(commit_done), 128'(1'b1));
      check("run_pending", 128'(commit_pending), 128'(1'b0));
      tick();
      check("done_pulse", 128'(commit_done), 128'(1'b0));

      // two frames with dp_tready toggling
      for (int k = 0; k < 16; k++) begin
         s_tvalid  = 4'hF;
         dp_tready = (k % 2 == 0);
         s_tlast   = (k % 8 == 6) ? 4'hF : 4'h0;
         #1;
         check("tog_fire", 128'(dp_fire), 128'(k % 2 == 0));
         check("tog_tready", 128'(s_tready), 128'((k % 2 == 0) ? 4'hF : 4'h0));
         check("tog_tlast", 128'(dp_tlast), 128'(k % 8 == 6));
         tick();
      end
      s_tlast = '0;
      check("tog_frames", 128'(frame_count), 128'(16'd2));
      check("tog_errs", 128'({err_misalign, err_frame_len}), 128'(2'b00));

      // mid-frame commit with a shadow update; old weights hold to tlast
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = 3'd0;
      cfg_wr_data = 9'h0AA;
      cfg_commit  = 1'b1;
      beat(4'h0);
      cfg_wr_en  = 1'b0;
      cfg_commit = 1'b0;
      check("mid_pending", 128'(commit_pending), 128'(1'b1));
      check("mid_weights", 128'(weights), 128'(packw()));
      beat(4'h0);
      beat(4'h0);
      beat(4'hF);
      check("mid_swap_state", 128'(dbg_state), 128'(2'd2));
      check("mid_swap_weights", 128'(weights), 128'(packw()));
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = 3'd1;
      cfg_wr_data = 9'h1F0;
      #1;
      check("mid_swap_tready", 128'(s_tready), 128'(4'h0));
      check("mid_swap_fire", 128'(dp_fire), 128'(1'b0));
      s_tvalid = 4'h0;
      tick();
      cfg_wr_en = 1'b0;
      w_exp[0] = 9'h0AA;
      check("mid_new_weights", 128'(weights), 128'(packw()));
      check("mid_done", 128'(commit_done), 128'(1'b1));
      check("mid_pending_clr", 128'(commit_pending), 128'(1'b0));
      check("mid_frames", 128'(frame_count), 128'(16'd3));

      // the write made during SWAP shows up only after the next commit
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      beat(4'h0);
      beat(4'h0);
      beat(4'h0);
      beat(4'hF);
      s_tvalid = 4'h0;
      tick();
      w_exp[1] = 9'h1F0;
      check("c2_weights", 128'(weights), 128'(packw()));
      check("c2_frames", 128'(frame_count), 128'(16'd4));

      // channel 2 tlast one beat early
      beat(4'h0);
      beat(4'h0);
      s_tvalid  = 4'hF;
      dp_tready = 1'b1;
      s_tlast   = 4'b0100;
      #1;
      check("mis_fire", 128'(dp_fire), 128'(1'b1));
      check("mis_tlast", 128'(dp_tlast), 128'(1'b0));
      tick();
      s_tlast = 4'h0;
      #1;
      check("drain_state", 128'(dbg_state), 128'(2'd3));
      check("drain_err", 128'({err_misalign, err_frame_len}), 128'(2'b10));
      check("drain_tready", 128'(s_tready), 128'(4'b1011));
      check("drain_fire", 128'(dp_fire), 128'(1'b0));
      check("drain_frames", 128'(frame_count), 128'(16'd4));
      tick();
      s_tlast = 4'hF;
      #1;
      check("drain_tready2", 128'(s_tready), 128'(4'b1011));
      tick();
      s_tlast = 4'h0;
      check("drain_exit", 128'(dbg_state), 128'(2'd1));
      beat(4'h0);
      beat(4'h0);
      beat(4'h0);
      beat(4'hF);
      check("realign_frames", 128'(frame_count), 128'(16'd5));
      check("realign_errs", 128'({err_misalign, err_frame_len}), 128'(2'b10));
      s_tvalid  = 4'h0;
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("mis_cleared", 128'(err_misalign), 128'(1'b0));

      // 6-beat frame: missing tlast at beat 3 (error set beats clear)
      beat(4'h0);
      beat(4'h0);
      beat(4'h0);
      err_clear = 1'b1;
      beat(4'h0);
      err_clear = 1'b0;
      check("flen_set", 128'(err_frame_len), 128'(1'b1));
      check("flen_frames", 128'(frame_count), 128'(16'd5));
      beat(4'h0);
      beat(4'hF);
      check("flen_frames2", 128'(frame_count), 128'(16'd6));
      s_tvalid  = 4'h0;
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      check("flen_cleared", 128'(err_frame_len), 128'(1'b0));
      beat(4'h0);
      beat(4'h0);
      beat(4'h0);
      beat(4'hF);
      check("wrap_ok", 128'(err_frame_len), 128'(1'b0));
      check("wrap_frames", 128'(frame_count), 128'(16'd7));

      // reset while in DRAIN with a commit pending
      s_tvalid   = 4'h0;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      beat(4'b0001);
      check("pre_rst_state", 128'(dbg_state), 128'(2'd3));
      check("pre_rst_pending", 128'(commit_pending), 128'(1'b1));
      reset = 1'b1;
      tick();
      #1;
      check("rst2_state", 128'(dbg_state), 128'(2'd0));
      check("rst2_weights", 128'(weights), 128'(72'd0));
      check("rst2_pending", 128'(commit_pending), 128'(1'b0));
      check("rst2_frames", 128'(frame_count), 128'(16'd0));
      check("rst2_errs", 128'({err_misalign, err_frame_len, commit_done}), 128'(3'b000));
      check("rst2_tready", 128'(s_tready), 128'(4'h0));
      reset = 1'b0;
      tick();
      #1;
      check("rst2_idle", 128'(dbg_state), 128'(2'd0));
      check("rst2_fire", 128'(dp_fire), 128'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
